// File: rtl/reg_bank_pn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pn_pkg
// Purpose  : Opcodes, state/command encodings and index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package reg_bank_pn_pkg;

  localparam logic [3:0] c_OP_NOP    = 4'd0;
  localparam logic [3:0] c_OP_LD     = 4'd1;
  localparam logic [3:0] c_OP_CLR    = 4'd2;
  localparam logic [3:0] c_OP_INC    = 4'd3;
  localparam logic [3:0] c_OP_DEC    = 4'd4;
  localparam logic [3:0] c_OP_CLRALL = 4'd5;
  localparam logic [3:0] c_OP_LDALL  = 4'd6;

  // Encoding 2'd3 is deliberately left out; the FSM recovers from it to Error.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'd0,
    CMD_LOAD  = 3'd1,
    CMD_CLEAR = 3'd2,
    CMD_INC   = 3'd3,
    CMD_DEC   = 3'd4
  } cell_cmd_t;

  function automatic int idx_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_pn_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pn_if
// Purpose  : Instruction/status bundle between a host and the register bank.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_bank_pn_if
  import reg_bank_pn_pkg::*;
#(
  parameter int COUNT = 8,
  parameter int WIDTH = 8
);
  localparam int c_IDXW  = idx_width(COUNT);
  localparam int c_INSTW = 4 + c_IDXW + WIDTH;

  logic [c_INSTW-1:0]     inst;
  logic                   inst_en;
  logic [COUNT*WIDTH-1:0] out;
  logic [COUNT-1:0]       upd;
  logic                   ready;
  logic                   error;

  modport master (output inst, output inst_en,
                  input  out,  input  upd, input ready, input error);
  modport slave  (input  inst, input  inst_en,
                  output out,  output upd, output ready, output error);
endinterface
`default_nettype wire

// File: rtl/reg_bank_pn_cell.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pn_cell
// Purpose  : One register with its update logic and change-pulse flop.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_pn_cell
  import reg_bank_pn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  cell_cmd_t        cmd,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value,
  output logic             upd
);
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_next;
  logic             r_upd;

  always_comb begin
    w_next = r_value;
    case (cmd)
      CMD_LOAD:  w_next = data;
      CMD_CLEAR: w_next = '0;
      CMD_INC:   w_next = r_value + WIDTH'(1);
      CMD_DEC:   w_next = r_value - WIDTH'(1);
      default:   w_next = r_value;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_value <= w_next;
      r_upd   <= (w_next != r_value);
    end
  end

  assign value = r_value;
  assign upd   = r_upd;

endmodule
`default_nettype wire

// File: rtl/reg_bank_pn.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pn
// Purpose  : Instruction-driven register bank with sticky error state.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_pn
  import reg_bank_pn_pkg::*;
#(
  parameter int COUNT = 8,
  parameter int WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  reg_bank_pn_if.slave bus
);
  localparam int c_IDXW  = idx_width(COUNT);
  localparam int c_INSTW = 4 + c_IDXW + WIDTH;

  logic [c_INSTW-1:0]     w_inst;
  logic [3:0]             w_op;
  logic [c_IDXW-1:0]      w_idx;
  logic [WIDTH-1:0]       w_imm;
  logic                   w_idx_ok;
  state_t                 r_state;
  state_t                 w_state_next;
  cell_cmd_t              w_all_cmd;
  cell_cmd_t              w_one_cmd;
  logic [COUNT*WIDTH-1:0] w_out;
  logic [COUNT-1:0]       w_upd;

  assign w_inst                = bus.inst;
  assign {w_op, w_idx, w_imm}  = w_inst;
  assign w_idx_ok              = (int'(w_idx) < COUNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_RESET;
    else        r_state <= w_state_next;
  end

  // w_all_cmd targets every cell and takes priority; w_one_cmd targets idx only.
  always_comb begin
    w_state_next = r_state;
    w_all_cmd    = CMD_HOLD;
    w_one_cmd    = CMD_HOLD;
    case (r_state)
      ST_RESET: w_state_next = ST_READY;
      ST_READY: begin
        if (bus.inst_en) begin
          case (w_op)
            c_OP_NOP:    w_one_cmd = CMD_HOLD;
            c_OP_LD:     w_one_cmd = CMD_LOAD;
            c_OP_CLR:    w_one_cmd = CMD_CLEAR;
            c_OP_INC:    w_one_cmd = CMD_INC;
            c_OP_DEC:    w_one_cmd = CMD_DEC;
            c_OP_CLRALL: w_all_cmd = CMD_CLEAR;
            c_OP_LDALL:  w_all_cmd = CMD_LOAD;
            default: begin
              w_state_next = ST_ERROR;
              w_all_cmd    = CMD_CLEAR;
            end
          endcase
          if (w_one_cmd != CMD_HOLD && !w_idx_ok) begin
            w_one_cmd    = CMD_HOLD;
            w_state_next = ST_ERROR;
            w_all_cmd    = CMD_CLEAR;
          end
        end
      end
      ST_ERROR: w_all_cmd = CMD_CLEAR;
      default: begin
        w_state_next = ST_ERROR;
        w_all_cmd    = CMD_CLEAR;
      end
    endcase
  end

  for (genvar k = 0; k < COUNT; k++) begin : g_cell
    cell_cmd_t w_cmd;

    assign w_cmd = (w_all_cmd != CMD_HOLD)     ? w_all_cmd :
                   (w_idx == c_IDXW'(k))       ? w_one_cmd : CMD_HOLD;

    reg_bank_pn_cell #(.WIDTH(WIDTH)) u_cell (
      .clock (clock),
      .reset (reset),
      .cmd   (w_cmd),
      .data  (w_imm),
      .value (w_out[k*WIDTH +: WIDTH]),
      .upd   (w_upd[k])
    );
  end

  assign bus.out   = w_out;
  assign bus.upd   = w_upd;
  assign bus.ready = (r_state == ST_READY);
  assign bus.error = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_pn.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_pn
// Purpose  : Directed self-checking bench for reg_bank_pn (COUNT=8 and 6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_pn;
  import reg_bank_pn_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  reg_bank_pn_if #(.COUNT(8), .WIDTH(8)) bus8 ();
  reg_bank_pn_if #(.COUNT(6), .WIDTH(8)) bus6 ();

  reg_bank_pn #(.COUNT(8), .WIDTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8.slave)
  );

  reg_bank_pn #(.COUNT(6), .WIDTH(8)) dut6 (
    .clock (clock),
    .reset (reset),
    .bus   (bus6.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [14:0] mk(input logic [3:0] op, input logic [2:0] idx,
                                     input logic [7:0] imm);
    return {op, idx, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic [3:0] op, input logic [2:0] idx,
                        input logic [7:0] imm, input logic en);
    @(negedge clock);
    bus8.inst    = mk(op, idx, imm);
    bus8.inst_en = en;
  endtask

  task automatic drive6(input logic [3:0] op, input logic [2:0] idx,
                        input logic [7:0] imm, input logic en);
    @(negedge clock);
    bus6.inst    = mk(op, idx, imm);
    bus6.inst_en = en;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [63:0] out_e, input logic [7:0] upd_e,
                      input logic rdy_e, input logic err_e);
    chk({tag, ".out"},   bus8.out,   out_e);
    chk({tag, ".upd"},   bus8.upd,   upd_e);
    chk({tag, ".ready"}, bus8.ready, rdy_e);
    chk({tag, ".error"}, bus8.error, err_e);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus8.inst    = '0;
    bus8.inst_en = 1'b0;
    bus6.inst    = '0;
    bus6.inst_en = 1'b0;

    // Reset takes effect without any clock edge
    #1 reset = 1'b0;
    #1;
    chk8("rst_async", 64'h0, 8'h00, 1'b0, 1'b0);

    // Release; an instruction offered on the Reset->Ready edge is ignored
    @(negedge clock);
    reset        = 1'b1;
    bus8.inst    = mk(c_OP_LD, 3'd1, 8'h77);
    bus8.inst_en = 1'b1;
    cyc();
    chk8("rst_exit", 64'h0, 8'h00, 1'b1, 1'b0);
    chk("rst_exit6.ready", bus6.ready, 1'b1);

    drive8(c_OP_LD, 3'd3, 8'hA5, 1'b1); cyc();
    chk8("ld3", 64'h00000000A5000000, 8'h08, 1'b1, 1'b0);

    drive8(c_OP_LD, 3'd7, 8'hFF, 1'b1); cyc();
    chk8("ld7", 64'hFF000000A5000000, 8'h80, 1'b1, 1'b0);
    drive8(c_OP_INC, 3'd7, 8'h12, 1'b1); cyc();
    chk8("inc7_wrap", 64'h00000000A5000000, 8'h80, 1'b1, 1'b0);
    drive8(c_OP_DEC, 3'd7, 8'h34, 1'b1); cyc();
    chk8("dec7_wrap", 64'hFF000000A5000000, 8'h80, 1'b1, 1'b0);
    drive8(c_OP_DEC, 3'd7, 8'h00, 1'b1); cyc();
    chk8("dec7", 64'hFE000000A5000000, 8'h80, 1'b1, 1'b0);

    drive8(c_OP_LD, 3'd7, 8'hFE, 1'b1); cyc();
    chk8("ld_same", 64'hFE000000A5000000, 8'h00, 1'b1, 1'b0);
    drive8(c_OP_LD, 3'd0, 8'h99, 1'b0); cyc();
    chk8("idle", 64'hFE000000A5000000, 8'h00, 1'b1, 1'b0);
    drive8(c_OP_NOP, 3'd0, 8'h99, 1'b1); cyc();
    chk8("nop", 64'hFE000000A5000000, 8'h00, 1'b1, 1'b0);

    drive8(c_OP_LDALL, 3'd5, 8'h3C, 1'b1); cyc();
    chk8("ldall", 64'h3C3C3C3C3C3C3C3C, 8'hFF, 1'b1, 1'b0);
    drive8(c_OP_CLRALL, 3'd2, 8'h3C, 1'b1); cyc();
    chk8("clrall", 64'h0, 8'hFF, 1'b1, 1'b0);

    drive8(c_OP_INC, 3'd0, 8'h55, 1'b1); cyc();
    chk8("inc0", 64'h0000000000000001, 8'h01, 1'b1, 1'b0);
    drive8(c_OP_CLR, 3'd0, 8'h55, 1'b1); cyc();
    chk8("clr0", 64'h0, 8'h01, 1'b1, 1'b0);
    drive8(c_OP_DEC, 3'd1, 8'h00, 1'b1); cyc();
    chk8("dec1_wrap", 64'h000000000000FF00, 8'h02, 1'b1, 1'b0);
    drive8(c_OP_LD, 3'd2, 8'h11, 1'b1); cyc();
    chk8("ld2", 64'h000000000011FF00, 8'h04, 1'b1, 1'b0);

    // Illegal opcode: registers clear on entry, Error is sticky
    drive8(4'd9, 3'd0, 8'h00, 1'b1); cyc();
    chk8("op9", 64'h0, 8'h06, 1'b0, 1'b1);
    drive8(c_OP_LD, 3'd0, 8'h11, 1'b1); cyc();
    chk8("err_sticky", 64'h0, 8'h00, 1'b0, 1'b1);

    @(negedge clock);
    bus8.inst_en = 1'b0;
    reset        = 1'b0;
    #1;
    chk8("err_rst", 64'h0, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    cyc();
    chk8("err_recover", 64'h0, 8'h00, 1'b1, 1'b0);

    // Out-of-range index on the 6-register instance
    drive6(c_OP_LD, 3'd5, 8'h12, 1'b1); cyc();
    chk("c6_ld5.out", bus6.out, 48'h120000000000);
    chk("c6_ld5.upd", bus6.upd, 6'h20);
    drive6(c_OP_LD, 3'd6, 8'h12, 1'b1); cyc();
    chk("c6_ld6.out",   bus6.out,   48'h0);
    chk("c6_ld6.upd",   bus6.upd,   6'h20);
    chk("c6_ld6.error", bus6.error, 1'b1);
    chk("c6_ld6.ready", bus6.ready, 1'b0);
    @(negedge clock);
    bus6.inst_en = 1'b0;

    // Asynchronous reset mid-cycle aborts a pending load
    drive8(c_OP_LD, 3'd2, 8'h33, 1'b1); cyc();
    chk8("ld2_33", 64'h0000000000330000, 8'h04, 1'b1, 1'b0);
    drive8(c_OP_LD, 3'd2, 8'h55, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk8("mid_rst", 64'h0, 8'h00, 1'b0, 1'b0);
    cyc();
    chk8("mid_rst_edge", 64'h0, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    cyc();
    chk8("mid_rst_exit", 64'h0, 8'h00, 1'b1, 1'b0);
    @(negedge clock);
    bus8.inst_en = 1'b0;
    cyc();
    chk8("mid_rst_idle", 64'h0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
